mult_share_arbiter: RTL and testbench
=====================================

# mult_share_arbiter

Round-robin scheduler that shares one sequential shift-add multiplier core among `N_REQ` requesters. Each requester offers an operand pair on a valid/ready channel. The block grants one requester at a time and sequences the core through `WIDTH` add/shift steps. It returns the product with the winner's ID on a single shared response channel. It sits between the client blocks and the multiplier datapath, and is the only block that drives the core.

## Interface
Parameters:
- `WIDTH`, default 4: operand width in bits; the product is `2*WIDTH` bits.
- `N_REQ`, default 3: number of requesters, at least 2.
- `ID_W`, default `$clog2(N_REQ)`: width of the requester ID.

Ports:
- `clk` input 1: the only clock; all logic is on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req_valid` input `N_REQ`: bit i means requester i offers an operand pair.
- `req_ready` output `N_REQ`: one-hot grant; bit i high means the pair is accepted this cycle.
- `req_a` input `N_REQ*WIDTH`: multiplicand for requester i at bits `[i*WIDTH +: WIDTH]`.
- `req_b` input `N_REQ*WIDTH`: multiplier for requester i, same packing as `req_a`.
- `rsp_valid` output 1: product available.
- `rsp_ready` input 1: consumer accepts the product.
- `rsp_id` output `ID_W`: index of the requester that owns the product.
- `rsp_p` output `2*WIDTH`: unsigned product `A*B`.
- `busy` output 1: high in any state other than IDLE.

## Operation
- The FSM has three states: IDLE, RUN and DONE.
- **IDLE**
  - If any `req_valid` bit is high, the winner is the first set bit found by searching upward from `ptr`, with wrap-around.
  - `req_ready[winner]` is high combinationally in the same cycle.
  - At the clock edge: `M` takes `a`; `Q` takes `b`; the accumulator `ACC` (`WIDTH+1` bits, carry bit included) clears to 0; `cnt` takes `WIDTH`; `id` takes the winner; `ptr` becomes `(winner+1) mod N_REQ`; the state goes to RUN.
  - If no `req_valid` bit is high, the block stays in IDLE.
- **RUN**
  - Each edge does one step: if `Q[0]` is 1, `ACC` takes `ACC[WIDTH-1:0] + M` including the carry out.
  - Then the concatenation `{ACC, Q}` shifts right logically by 1.
  - `cnt` decrements.
  - When `cnt` reaches 1 at the edge, the state goes to DONE.
  - There is no early termination: zero operands still take `WIDTH` steps.
- **DONE**
  - `rsp_valid` is 1, `rsp_p` = `{ACC[WIDTH-1:0], Q}` and `rsp_id` = `id`.
  - All three outputs stay stable until `rsp_ready` is high.
  - On the accepting edge the state goes to IDLE.
- `req_ready` is all-zero outside IDLE; new requests wait.
- Requesters must hold `req_valid` and their operands until granted. Dropping `req_valid` before grant is legal; that requester is simply not considered.
- Unsigned arithmetic only. The product never overflows `2*WIDTH` bits; the carry bit is internal to the step.

## Timing
- Reset values:
  - Outputs: `req_ready`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_p`=0, `busy`=0.
  - Internal: state IDLE, `ptr`=0, `cnt`=0.
- **Latency**
  - The handshake happens in cycle 0; RUN covers cycles 1..`WIDTH`.
  - `rsp_valid` is first high in cycle `WIDTH+1`.
- **Throughput:** at most one operation per `WIDTH+2` cycles. DONE is accepted, then one IDLE cycle follows before the next grant.
- **Simultaneous requests:** exactly one grant per IDLE cycle. With all requesters continuously valid, the grant order is 0,1,…,`N_REQ-1`,0,…
- **Response backpressure:** stay in DONE indefinitely with the outputs frozen. No new grant is issued while DONE.
- **Reset mid-operation:** reset in RUN or DONE aborts the operation. No response is produced, and all state returns to its reset value on that edge.
- `rsp_ready` is ignored outside DONE.

## Structure
- **Package `mult_pkg`**
  - State typedef: IDLE, RUN, DONE.
  - Default constants `MULT_WIDTH`=4 and `MULT_N_REQ`=3.
  - Helper function for the round-robin pick: request vector plus pointer in, winner index and found flag out.
- **Sub-module `shift_add_core`**
  - Holds the `M`, `Q` and `ACC` registers and the step logic.
  - Ports: `clk`, `rst`, `load`, `step`, `a`, `b`, `p`.
  - The arbiter keeps the FSM, `cnt`, `ptr`, `id` and the handshakes.

## Test plan
- **Single request:** requester 0 sends a=8, b=4 → `req_ready[0]` is high in the same cycle; `rsp_valid` rises exactly 5 cycles later with `rsp_p`=32 and `rsp_id`=0.
- **Maximum and zero operands:** 15×15 → 225; 0×9 → 0; 9×0 → 0. Each case has latency `WIDTH+1`.
- **Round robin:** all three requesters hold valid from reset (a=i+1, b=3) → grant order 0,1,2,0; products 3,6,9,3.
- **Response backpressure:** hold `rsp_ready` low for 6 cycles in DONE → `rsp_valid`, `rsp_p` and `rsp_id` stay constant; `req_ready` stays 0; completion follows the first `rsp_ready` cycle.
- **Reset mid-RUN:** assert `rst` on cycle 2 of RUN → all outputs are 0 on the next cycle; no `rsp_valid` appears; a fresh 7×6 afterwards returns 42.
- **Pointer wrap:** only requester 2 is valid, then 0 and 2 are valid together → the first grant goes to 2, the next to 0.

Source files
------------

// File: rtl/mult_pkg.sv
// mult_pkg: shared types, default constants and the round-robin pick helper
// for the multiplier-sharing arbiter.
//   state_t    - arbiter FSM states (IDLE, RUN, DONE)
//   MULT_WIDTH - default operand width
//   MULT_N_REQ - default number of requesters
//   rr_pick()  - request vector + pointer in, {found, winner index} out
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int MULT_WIDTH = 4;
  localparam int MULT_N_REQ = 3;

  // Widest request vector the pick helper handles; callers zero-pad.
  localparam int RR_MAX = 32;

  typedef struct packed {
    logic        found;
    logic [31:0] idx;
  } rr_pick_t;

  // First set bit at or above ptr, wrapping at n. Offsets are visited in
  // increasing order and the first hit latches, so the lowest offset wins.
  function automatic rr_pick_t rr_pick(input logic [RR_MAX-1:0] req,
                                       input int unsigned ptr,
                                       input int unsigned n);
    rr_pick_t    res;
    int unsigned pos;
    res.found = 1'b0;
    res.idx   = '0;
    for (int unsigned k = 0; k < RR_MAX; k++) begin
      pos = ptr + k;
      if (pos >= n) pos = pos - n;
      if ((k < n) && !res.found && req[pos[4:0]]) begin
        res.found = 1'b1;
        res.idx   = pos;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/shift_add_core.sv
// shift_add_core: sequential unsigned shift-add multiplier datapath.
// Holds the multiplicand M, the multiplier/low-product register Q and the
// WIDTH+1 bit accumulator ACC (top bit is the step carry).
// Ports:
//   clk, rst - clock and synchronous active-high reset
//   load     - capture a into M, b into Q and clear ACC
//   step     - one add/shift step
//   a, b     - operands (WIDTH bits)
//   p        - product {ACC[WIDTH-1:0], Q} (2*WIDTH bits), valid after WIDTH steps
module shift_add_core
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] p
);

  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH:0]   acc_q, acc_d;
  logic [WIDTH:0]   sum;

  always_comb begin
    m_d   = m_q;
    q_d   = q_q;
    acc_d = acc_q;
    // Conditional add keeps the carry in bit WIDTH so the shift below
    // brings it back into the product.
    sum   = q_q[0] ? ({1'b0, acc_q[WIDTH-1:0]} + {1'b0, m_q}) : acc_q;
    if (load) begin
      m_d   = a;
      q_d   = b;
      acc_d = '0;
    end else if (step) begin
      // {ACC, Q} >> 1 after the add.
      acc_d = {1'b0, sum[WIDTH:1]};
      q_d   = {sum[0], q_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_q   <= '0;
      q_q   <= '0;
      acc_q <= '0;
    end else begin
      m_q   <= m_d;
      q_q   <= q_d;
      acc_q <= acc_d;
    end
  end

  assign p = {acc_q[WIDTH-1:0], q_q};

endmodule

// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter: round-robin scheduler sharing one shift-add multiplier
// core among N_REQ requesters.
// Ports:
//   clk, rst   - clock and synchronous active-high reset
//   req_valid  - per-requester operand offer
//   req_ready  - one-hot grant, only ever high in IDLE
//   req_a/b    - packed operands, requester i at [i*WIDTH +: WIDTH]
//   rsp_valid  - product available (DONE state)
//   rsp_ready  - consumer accepts product
//   rsp_id     - requester that owns the product
//   rsp_p      - unsigned product, 2*WIDTH bits
//   busy       - high whenever not IDLE
module mult_share_arbiter
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH,
  parameter int N_REQ = MULT_N_REQ,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [2*WIDTH-1:0]     rsp_p,
  output logic                   busy
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0]   id_q, id_d;

  logic [RR_MAX-1:0] req_pad;
  rr_pick_t          pick;
  logic [ID_W-1:0]   win_idx;
  logic [WIDTH-1:0]  a_sel;
  logic [WIDTH-1:0]  b_sel;
  logic              core_load;
  logic              core_step;
  logic [2*WIDTH-1:0] core_p;
  logic              unused_pick_bits;

  always_comb begin
    req_pad              = '0;
    req_pad[N_REQ-1:0]   = req_valid;
    pick                 = rr_pick(req_pad, 32'(ptr_q), 32'(N_REQ));
    win_idx              = ID_W'(pick.idx);
    a_sel                = req_a[int'(win_idx)*WIDTH +: WIDTH];
    b_sel                = req_b[int'(win_idx)*WIDTH +: WIDTH];
  end

  // Only the low ID_W bits of the pick index carry information.
  assign unused_pick_bits = ^pick.idx;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    id_d      = id_q;
    req_ready = '0;
    core_load = 1'b0;
    core_step = 1'b0;
    rsp_valid = 1'b0;
    rsp_id    = '0;
    rsp_p     = '0;
    unique case (state_q)
      IDLE: begin
        if (pick.found) begin
          req_ready[win_idx] = 1'b1;
          core_load          = 1'b1;
          cnt_d              = CNT_W'(WIDTH);
          id_d               = win_idx;
          ptr_d              = (win_idx == ID_W'(N_REQ - 1)) ? '0 : win_idx + ID_W'(1);
          state_d            = RUN;
        end
      end
      RUN: begin
        // Fixed WIDTH steps; the step taken while cnt is 1 is the last one.
        core_step = 1'b1;
        cnt_d     = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = DONE;
      end
      DONE: begin
        // Core is idle here, so the product and id are naturally frozen.
        rsp_valid = 1'b1;
        rsp_id    = id_q;
        rsp_p     = core_p;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
    end
  end

  assign busy = (state_q != IDLE);

  shift_add_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk  (clk),
    .rst  (rst),
    .load (core_load),
    .step (core_step),
    .a    (a_sel),
    .b    (b_sel),
    .p    (core_p)
  );

endmodule

// File: tb/tb_mult_share_arbiter.sv
module tb_mult_share_arbiter;
  localparam int W   = 4;
  localparam int N   = 3;
  localparam int IDW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [IDW-1:0] rsp_id;
  logic [2*W-1:0] rsp_p;
  logic           busy;

  int checks = 0;
  int errors = 0;
  int model_ptr = 0;
  int op_a [N];
  int op_b [N];

  always #5 clk = ~clk;

  mult_share_arbiter #(.WIDTH(W), .N_REQ(N), .ID_W(IDW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_p(rsp_p), .busy(busy)
  );

  // Reference: first valid requester at or after the pointer, wrapping.
  function automatic int model_pick(input logic [N-1:0] vld, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (vld[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic set_ops(input int i, input int a, input int b);
    op_a[i] = a;
    op_b[i] = b;
    req_a[i*W +: W] = W'(a);
    req_b[i*W +: W] = W'(b);
  endtask

  // Drives one operation to completion and reports what was observed.
  task automatic run_op(input logic [N-1:0] vld, input int bp,
                        output logic [N-1:0] grant, output int lat,
                        output logic [2*W-1:0] p, output logic [IDW-1:0] id,
                        output bit stable_ok, output bit timeout,
                        output bit idle_after);
    int cyc;
    timeout = 0; stable_ok = 1; lat = 0; grant = '0; p = '0; id = '0;
    idle_after = 0;
    @(negedge clk);
    req_valid = vld;
    rsp_ready = 1'b0;
    #1;
    cyc = 0;
    while (req_ready == '0 && cyc < 50) begin
      @(negedge clk); #1; cyc++;
    end
    if (req_ready == '0) begin
      timeout = 1;
      req_valid = '0;
      return;
    end
    grant = req_ready;
    @(negedge clk);
    req_valid = req_valid & ~grant;
    #1;
    lat = 1;
    while (!rsp_valid && lat < 50) begin
      @(negedge clk); #1; lat++;
    end
    if (!rsp_valid) begin
      timeout = 1;
      return;
    end
    p  = rsp_p;
    id = rsp_id;
    for (int k = 0; k < bp; k++) begin
      @(negedge clk); #1;
      if (!rsp_valid || rsp_p !== p || rsp_id !== id || req_ready !== '0)
        stable_ok = 0;
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    idle_after = (busy === 1'b0 && rsp_valid === 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req_valid = '0; rsp_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_ptr = 0;
  endtask

  // Runs one op against the model and compares grant, latency, product, id.
  task automatic check_op(input string name, input logic [N-1:0] vld, input int bp);
    logic [N-1:0]   grant;
    int             lat;
    logic [2*W-1:0] p;
    logic [IDW-1:0] id;
    bit             stable_ok, timeout, idle_after;
    int             w;
    int             exp_p;
    w = model_pick(vld, model_ptr);
    exp_p = op_a[w] * op_b[w];
    run_op(vld, bp, grant, lat, p, id, stable_ok, timeout, idle_after);
    model_ptr = (w + 1) % N;
    $display("op %s: valid=%b grant=%b id=%0d p=%0d lat=%0d bp=%0d", name, vld, grant, id, p, lat, bp);
    checks++;
    if (timeout) begin
      errors++;
      $display("FAIL %s timeout: no grant or response within bound", name);
      return;
    end
    checks++;
    if (grant !== N'(1 << w)) begin
      errors++;
      $display("FAIL %s grant: got %b expected %b", name, grant, N'(1 << w));
    end
    checks++;
    if (lat !== W + 1) begin
      errors++;
      $display("FAIL %s latency: got %0d expected %0d", name, lat, W + 1);
    end
    checks++;
    if (p !== (2*W)'(exp_p)) begin
      errors++;
      $display("FAIL %s product: got %0d expected %0d", name, p, exp_p);
    end
    checks++;
    if (id !== IDW'(w)) begin
      errors++;
      $display("FAIL %s id: got %0d expected %0d", name, id, w);
    end
    checks++;
    if (!stable_ok) begin
      errors++;
      $display("FAIL %s stability: outputs changed or grant seen while held in DONE (bp=%0d)", name, bp);
    end
    checks++;
    if (!idle_after) begin
      errors++;
      $display("FAIL %s accept: busy=%b rsp_valid=%b after accept, expected 0 0", name, busy, rsp_valid);
    end
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if ({req_ready, rsp_valid, rsp_id, rsp_p, busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: req_ready=%b rsp_valid=%b rsp_id=%0d rsp_p=%0d busy=%b, expected all 0",
               req_ready, rsp_valid, rsp_id, rsp_p, busy);
    end
  endtask

  task automatic test_single();
    set_ops(0, 8, 4);
    check_op("single_8x4", 3'b001, 0);
  endtask

  task automatic test_operands();
    int ta [3] = '{15, 0, 9};
    int tb [3] = '{15, 9, 0};
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < N; i++) set_ops(i, ta[c], tb[c]);
      check_op($sformatf("operands_%0dx%0d", ta[c], tb[c]), N'(1 << c), 0);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < N; i++) set_ops(i, i + 1, 3);
    for (int k = 0; k < 4; k++) check_op($sformatf("round_robin_%0d", k), 3'b111, 0);
  endtask

  task automatic test_backpressure();
    set_ops(1, 13, 11);
    check_op("backpressure", 3'b010, 6);
  endtask

  task automatic test_reset_mid_run();
    int seen;
    do_reset();
    set_ops(0, 3, 3);
    @(negedge clk);
    req_valid = 3'b001;
    #1;
    checks++;
    if (req_ready !== 3'b001) begin
      errors++;
      $display("FAIL mid_run_grant: got %b expected 001", req_ready);
    end
    @(negedge clk); req_valid = '0;  // RUN cycle 1
    @(negedge clk);                  // RUN cycle 2
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({req_ready, rsp_valid, rsp_id, rsp_p, busy} !== '0) begin
      errors++;
      $display("FAIL mid_run_reset: req_ready=%b rsp_valid=%b rsp_id=%0d rsp_p=%0d busy=%b, expected all 0",
               req_ready, rsp_valid, rsp_id, rsp_p, busy);
    end
    @(negedge clk);
    rst = 1'b0;
    model_ptr = 0;
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); #1;
      if (rsp_valid) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL mid_run_no_rsp: rsp_valid seen %0d cycles, expected 0", seen);
    end
    // Pointer must be back at 0: with 0 and 1 valid, 0 wins.
    set_ops(0, 7, 6);
    set_ops(1, 2, 2);
    check_op("after_reset_7x6", 3'b011, 0);
  endtask

  task automatic test_pointer_wrap();
    do_reset();
    set_ops(0, 5, 3);
    set_ops(2, 6, 7);
    check_op("wrap_first", 3'b100, 0);
    check_op("wrap_second", 3'b101, 0);
  endtask

  task automatic test_random();
    logic [N-1:0] vld;
    for (int t = 0; t < 30; t++) begin
      for (int i = 0; i < N; i++) set_ops(i, $urandom_range(0, 15), $urandom_range(0, 15));
      vld = N'($urandom_range(1, (1 << N) - 1));
      check_op($sformatf("random_%0d", t), vld, $urandom_range(0, 3));
    end
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    rsp_ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      op_a[i] = 0;
      op_b[i] = 0;
    end
    test_reset();
    test_single();
    test_operands();
    test_round_robin();
    test_backpressure();
    test_reset_mid_run();
    test_pointer_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
